sram_banked_port: RTL and testbench

- Parametrised multi-bank on-chip SRAM with a valid/ready request channel and an in-order valid/ready read-response channel.
- Built from NUM_BANKS single-port 64k-style bank macros (1-cycle read latency, active-low byte write enables).
- Adds three things the fixed 8-bank SRAM wrapper does not have:
  - back-pressure tolerance, via a response buffer;
  - non-power-of-two bank counts, with out-of-range error reporting;
  - bank-index latching only on accepted reads.
- Sits between a bus slave wrapper and the bank macros; replaces the fixed 512kB wrapper.

---
 rtl/sram_pkg.sv | 18 +
 rtl/sram_rsp_fifo.sv | 64 ++++++
 rtl/sram_banked_port.sv | 146 ++++++++++++++
 tb/tb_sram_banked_port.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared defaults, helper function and response record for the banked SRAM port.
package sram_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_BANK_AW = 14;

  function automatic int clog2(input int value);
    int r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  typedef struct packed {
    logic                  err;
    logic [DEF_DATA_W-1:0] data;
  } rsp_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small synchronous FIFO of read responses with an occupancy count; head is always visible.
module sram_rsp_fifo
  import sram_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = rsp_t,
  parameter int  CNT_W   = clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  entry_t           din_i,
  input  logic             pop_i,
  output entry_t           head_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push_i && !pop_i) assert (32'(count_q) < DEPTH);
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/sram_banked_port.sv
// Multi-bank SRAM behind a valid/ready request channel, with an in-order, back-pressurable
// read-response channel; out-of-range banks answer reads with an error and drop writes.
module sram_banked_port
  import sram_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int BANK_AW    = DEF_BANK_AW,
  parameter int NUM_BANKS  = 8,
  parameter int BANK_SEL_W = (clog2(NUM_BANKS) > 0) ? clog2(NUM_BANKS) : 1,
  parameter int AW         = BANK_AW + BANK_SEL_W,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                CK,
  input  logic                RST,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [DATA_W/8-1:0] req_wstrb,
  input  logic [AW-1:0]       req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [BANK_SEL_W-1:0] req_bank;
  logic [BANK_AW-1:0]    req_word;
  logic                  req_oor;
  logic                  accept;
  logic                  rd_accept;

  logic                  inflight_q, inflight_d;
  logic                  err_q, err_d;
  logic [BANK_SEL_W-1:0] sel_q, sel_d;

  logic [NUM_BANKS-1:0]  bank_cs;
  logic [NUM_BANKS-1:0]  bank_oe;
  logic [NB-1:0]         bank_web  [NUM_BANKS];
  logic [DATA_W-1:0]     bank_dout [NUM_BANKS];
  logic [DATA_W-1:0]     mac_data;

  entry_t                mac_rsp;
  entry_t                head_rsp;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;

  assign req_bank  = req_addr[AW-1:BANK_AW];
  assign req_word  = req_addr[BANK_AW-1:0];
  assign req_oor   = 32'(req_bank) >= NUM_BANKS;
  assign accept    = req_valid && req_ready && !RST;
  assign rd_accept = accept && (req_wstrb == '0);

  // Credit counts the read in flight, so rsp_ready never reaches req_ready combinationally.
  assign req_ready = !RST && ((32'(fifo_count) + 32'(inflight_q)) < RSP_DEPTH);

  assign sel_d      = rd_accept ? req_bank : sel_q;
  assign err_d      = rd_accept ? req_oor  : err_q;
  assign inflight_d = rd_accept;

  always_ff @(posedge CK) begin
    if (RST) begin
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
      sel_q      <= '0;
    end else begin
      inflight_q <= inflight_d;
      err_q      <= err_d;
      sel_q      <= sel_d;
    end
  end

  // Behavioural stand-in for the bank macro: CS/active-low WEB, one-cycle registered read.
  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic [DATA_W-1:0] mem [2**BANK_AW];
    logic [DATA_W-1:0] q_q;

    assign bank_cs[gi]  = accept && (req_bank == BANK_SEL_W'(gi));
    assign bank_web[gi] = bank_cs[gi] ? ~req_wstrb : '1;
    assign bank_oe[gi]  = inflight_q && (sel_q == BANK_SEL_W'(gi));

    always_ff @(posedge CK) begin
      if (bank_cs[gi]) begin
        for (int b = 0; b < NB; b++) begin
          if (!bank_web[gi][b]) mem[req_word][b*8 +: 8] <= req_wdata[b*8 +: 8];
        end
        if (&bank_web[gi]) q_q <= mem[req_word];
      end
    end

    assign bank_dout[gi] = bank_oe[gi] ? q_q : '0;
  end

  always_comb begin
    mac_data = '0;
    for (int b = 0; b < NUM_BANKS; b++) mac_data = mac_data | bank_dout[b];
  end

  assign mac_rsp.err  = inflight_q && err_q;
  assign mac_rsp.data = err_q ? '0 : mac_data;

  // Buffered responses are older than the one in flight, so the head wins over bypass.
  assign fifo_empty = (fifo_count == '0);
  assign push       = inflight_q && (!fifo_empty || !rsp_ready);
  assign pop        = !fifo_empty && rsp_ready;

  sram_rsp_fifo #(
    .DEPTH   (RSP_DEPTH),
    .entry_t (entry_t),
    .CNT_W   (CNT_W)
  ) u_rsp_fifo (
    .clk_i   (CK),
    .rst_i   (RST),
    .push_i  (push),
    .din_i   (mac_rsp),
    .pop_i   (pop),
    .head_o  (head_rsp),
    .count_o (fifo_count)
  );

  always_comb begin
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    if (!RST) begin
      rsp_valid = !fifo_empty || inflight_q;
      if (fifo_empty) begin
        rsp_rdata = mac_rsp.data;
        rsp_err   = mac_rsp.err;
      end else begin
        rsp_rdata = head_rsp.data;
        rsp_err   = head_rsp.err;
      end
    end
  end

endmodule

// File: tb/tb_sram_banked_port.sv
// Directed bench for sram_banked_port with five banks: data path, byte strobes,
// out-of-range banks, streaming, back-pressure and mid-operation reset.
module tb_sram_banked_port;

  localparam int AW = 17;

  logic        CK;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_wstrb;
  logic [AW-1:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_asserts = 0;
  int n_fail    = 0;

  sram_banked_port #(
    .DATA_W    (32),
    .BANK_AW   (14),
    .NUM_BANKS (5),
    .RSP_DEPTH (2)
  ) dut (
    .CK        (CK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wstrb (req_wstrb),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, expected end before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  // One write, checking it is accepted and which bank chip-select fires.
  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [4:0] exp_cs);
    req_valid = 1'b1;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
    #1;
    check("wr_ready", 32'(req_ready), 32'd1);
    check("wr_cs", 32'(dut.bank_cs), 32'(exp_cs));
    tick();
    req_valid = 1'b0;
    req_wstrb = 4'h0;
    $display("txn write addr=%h data=%h strb=%h", a, d, s);
  endtask

  // One read with rsp_ready high; the response must appear the cycle after accept.
  task automatic do_read(input logic [AW-1:0] a, input logic [31:0] exp_d, input logic exp_e);
    req_valid = 1'b1;
    req_addr  = a;
    req_wstrb = 4'h0;
    rsp_ready = 1'b1;
    #1;
    check("rd_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    #1;
    check("rd_valid", 32'(rsp_valid), 32'd1);
    check("rd_data", rsp_rdata, exp_d);
    check("rd_err", 32'(rsp_err), 32'(exp_e));
    $display("txn read addr=%h data=%h err=%0d", a, rsp_rdata, rsp_err);
    tick();
  endtask

  initial begin
    RST       = 1'b1;
    req_valid = 1'b0;
    req_wstrb = 4'h0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    RST = 1'b0;
    #1;
    check("post_rst_req_ready", 32'(req_ready), 32'd1);
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_rst_rdata", rsp_rdata, 32'd0);
    check("post_rst_err", 32'(rsp_err), 32'd0);
    tick();

    // Basic write/read
    do_write(17'h04010, 32'hDEADBEEF, 4'hF, 5'b00010);
    do_read(17'h04010, 32'hDEADBEEF, 1'b0);

    // Byte strobe merge, read directly after the partial write
    do_write(17'h00000, 32'h11223344, 4'hF, 5'b00001);
    do_write(17'h00000, 32'h0000AA00, 4'h2, 5'b00001);
    do_read(17'h00000, 32'h1122AA44, 1'b0);

    // Fill word 0 of banks 1..4, then target the nonexistent banks 5 and 6
    do_write(17'h04000, 32'hA1A10001, 4'hF, 5'b00010);
    do_write(17'h08000, 32'hA2A20002, 4'hF, 5'b00100);
    do_write(17'h0C000, 32'hA3A30003, 4'hF, 5'b01000);
    do_write(17'h10000, 32'hA4A40004, 4'hF, 5'b10000);
    do_write(17'h18000, 32'hBAD0BAD0, 4'hF, 5'b00000);
    do_read(17'h18000, 32'h00000000, 1'b1);
    do_read(17'h14000, 32'h00000000, 1'b1);
    do_read(17'h00000, 32'h1122AA44, 1'b0);
    do_read(17'h04000, 32'hA1A10001, 1'b0);
    do_read(17'h08000, 32'hA2A20002, 1'b0);
    do_read(17'h0C000, 32'hA3A30003, 1'b0);
    do_read(17'h10000, 32'hA4A40004, 1'b0);

    // Four back-to-back reads, one response per cycle in order
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_wstrb = 4'h0;
    req_addr  = 17'h00000;
    #1;
    check("b2b_ready0", 32'(req_ready), 32'd1);
    tick();
    req_addr = 17'h04000;
    #1;
    check("b2b_ready1", 32'(req_ready), 32'd1);
    check("b2b_valid0", 32'(rsp_valid), 32'd1);
    check("b2b_data0", rsp_rdata, 32'h1122AA44);
    $display("txn stream rsp0 data=%h", rsp_rdata);
    tick();
    req_addr = 17'h08000;
    #1;
    check("b2b_ready2", 32'(req_ready), 32'd1);
    check("b2b_valid1", 32'(rsp_valid), 32'd1);
    check("b2b_data1", rsp_rdata, 32'hA1A10001);
    $display("txn stream rsp1 data=%h", rsp_rdata);
    tick();
    req_addr = 17'h0C000;
    #1;
    check("b2b_ready3", 32'(req_ready), 32'd1);
    check("b2b_valid2", 32'(rsp_valid), 32'd1);
    check("b2b_data2", rsp_rdata, 32'hA2A20002);
    $display("txn stream rsp2 data=%h", rsp_rdata);
    tick();
    req_valid = 1'b0;
    #1;
    check("b2b_valid3", 32'(rsp_valid), 32'd1);
    check("b2b_data3", rsp_rdata, 32'hA3A30003);
    $display("txn stream rsp3 data=%h", rsp_rdata);
    tick();
    check("b2b_idle", 32'(rsp_valid), 32'd0);

    // Back-pressure: three reads with rsp_ready low
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 17'h04010;
    #1;
    check("bp_ready_a", 32'(req_ready), 32'd1);
    tick();
    req_addr = 17'h00000;
    #1;
    check("bp_ready_b", 32'(req_ready), 32'd1);
    check("bp_valid_b", 32'(rsp_valid), 32'd1);
    check("bp_data_b", rsp_rdata, 32'hDEADBEEF);
    tick();
    req_addr = 17'h04000;
    #1;
    check("bp_ready_drop", 32'(req_ready), 32'd0);
    check("bp_hold1", rsp_rdata, 32'hDEADBEEF);
    tick();
    #1;
    check("bp_ready_full", 32'(req_ready), 32'd0);
    check("bp_hold2_valid", 32'(rsp_valid), 32'd1);
    check("bp_hold2", rsp_rdata, 32'hDEADBEEF);
    tick();
    rsp_ready = 1'b1;
    #1;
    check("bp_no_comb_ready", 32'(req_ready), 32'd0);
    check("bp_pop0", rsp_rdata, 32'hDEADBEEF);
    $display("txn drain rsp0 data=%h", rsp_rdata);
    tick();
    #1;
    check("bp_ready_back", 32'(req_ready), 32'd1);
    check("bp_pop1_valid", 32'(rsp_valid), 32'd1);
    check("bp_pop1", rsp_rdata, 32'h1122AA44);
    $display("txn drain rsp1 data=%h", rsp_rdata);
    tick();
    req_valid = 1'b0;
    #1;
    check("bp_pop2_valid", 32'(rsp_valid), 32'd1);
    check("bp_pop2", rsp_rdata, 32'hA1A10001);
    $display("txn drain rsp2 data=%h", rsp_rdata);
    tick();
    check("bp_drained", 32'(rsp_valid), 32'd0);

    // Reset with two responses buffered
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 17'h08000;
    tick();
    req_addr = 17'h0C000;
    tick();
    req_valid = 1'b0;
    tick();
    check("rb_buffered", 32'(rsp_valid), 32'd1);
    check("rb_full", 32'(req_ready), 32'd0);
    RST = 1'b1;
    tick();
    RST       = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("rb_valid_cleared", 32'(rsp_valid), 32'd0);
    check("rb_ready", 32'(req_ready), 32'd1);
    $display("txn reset with two responses buffered");
    tick();
    check("rb_no_stale", 32'(rsp_valid), 32'd0);
    check("rb_ready_hold", 32'(req_ready), 32'd1);
    do_read(17'h08000, 32'hA2A20002, 1'b0);
    do_read(17'h04010, 32'hDEADBEEF, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
